// File: rtl/hit_resolver.sv
`default_nettype none
// ============================================================================
// Module   : hit_resolver
// Brief    : Resolves attacker-hitbox vs defender-hurtbox overlaps between
//            the two players during active attack frames, emits one-cycle
//            hitFlag pulses, tracks both health bars and latches round end.
// Revision : 1.0 - initial release
// ============================================================================
module hit_resolver #(
    parameter int HEALTH_INIT = 100,
    parameter int DMG_BASIC   = 10,
    parameter int DMG_DIR     = 15,
    parameter int DMG_CHIP    = 2
) (
    input  logic       clk,
    input  logic       rst,

    // Player 1 (left side)
    input  logic [3:0] p1_state,
    input  logic [9:0] p1_basic_x1,
    input  logic [9:0] p1_basic_x2,
    input  logic [9:0] p1_basic_y1,
    input  logic [9:0] p1_basic_y2,
    input  logic [9:0] p1_dir_x1,
    input  logic [9:0] p1_dir_x2,
    input  logic [9:0] p1_dir_y1,
    input  logic [9:0] p1_dir_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,

    // Player 2 (right side)
    input  logic [3:0] p2_state,
    input  logic [9:0] p2_basic_x1,
    input  logic [9:0] p2_basic_x2,
    input  logic [9:0] p2_basic_y1,
    input  logic [9:0] p2_basic_y2,
    input  logic [9:0] p2_dir_x1,
    input  logic [9:0] p2_dir_x2,
    input  logic [9:0] p2_dir_y1,
    input  logic [9:0] p2_dir_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,

    output logic [1:0] p1_hitFlag,
    output logic [1:0] p2_hitFlag,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic       round_over,
    output logic [1:0] winner
);

    // Player state codes that matter here. HITSTUN (9) needs no special
    // handling: a defender in hitstun is simply hittable again (combos).
    localparam logic [3:0] C_ST_MOVEBACK  = 4'd2;
    localparam logic [3:0] C_ST_B_END     = 4'd4;
    localparam logic [3:0] C_ST_D_END     = 4'd7;
    localparam logic [3:0] C_ST_BLOCKSTUN = 4'd10;

    localparam logic [7:0] C_HEALTH_INIT  = 8'(HEALTH_INIT);
    localparam logic [7:0] C_DMG_BASIC    = 8'(DMG_BASIC);
    localparam logic [7:0] C_DMG_DIR      = 8'(DMG_DIR);
    localparam logic [7:0] C_DMG_CHIP     = 8'(DMG_CHIP);

    localparam logic [1:0] C_FLAG_NONE    = 2'b00;
    localparam logic [1:0] C_FLAG_BASIC   = 2'b01;
    localparam logic [1:0] C_FLAG_DIR     = 2'b10;

    localparam logic [1:0] C_WIN_NONE     = 2'b00;
    localparam logic [1:0] C_WIN_P1       = 2'b01;
    localparam logic [1:0] C_WIN_P2       = 2'b10;
    localparam logic [1:0] C_WIN_DRAW     = 2'b11;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [9:0] f_lo(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] f_hi(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? b : a;
    endfunction

    // Inclusive overlap of two boxes given as raw corner pairs. Corners are
    // normalised first because the right-side player's boxes are mirrored
    // (x1 > x2).
    function automatic logic f_overlap(
        input logic [9:0] a_x1, input logic [9:0] a_x2,
        input logic [9:0] a_y1, input logic [9:0] a_y2,
        input logic [9:0] b_x1, input logic [9:0] b_x2,
        input logic [9:0] b_y1, input logic [9:0] b_y2
    );
        logic w_x_ov;
        logic w_y_ov;
        w_x_ov = (f_lo(a_x1, a_x2) <= f_hi(b_x1, b_x2)) &&
                 (f_lo(b_x1, b_x2) <= f_hi(a_x1, a_x2));
        w_y_ov = (f_lo(a_y1, a_y2) <= f_hi(b_y1, b_y2)) &&
                 (f_lo(b_y1, b_y2) <= f_hi(a_y1, a_y2));
        return w_x_ov && w_y_ov;
    endfunction

    // Health never wraps: any damage at or above the remaining health
    // lands exactly on zero.
    function automatic logic [7:0] f_sat_sub(input logic [7:0] h, input logic [7:0] d);
        return (h > d) ? (h - d) : 8'd0;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] r_p1_flag;
    logic [1:0] r_p2_flag;
    logic [7:0] r_p1_health;
    logic [7:0] r_p2_health;
    logic       r_round_over;
    logic [1:0] r_winner;
    logic       r_p1_connected;
    logic       r_p2_connected;

    // ------------------------------------------------------------------------
    // Combinational hit detection
    // ------------------------------------------------------------------------
    logic       w_p1_in_basic;
    logic       w_p1_in_dir;
    logic       w_p2_in_basic;
    logic       w_p2_in_dir;
    logic       w_p1_attacking;
    logic       w_p2_attacking;
    logic       w_p1_basic_ov;
    logic       w_p1_dir_ov;
    logic       w_p2_basic_ov;
    logic       w_p2_dir_ov;
    logic       w_p1_hits;       // p1 lands a hit on p2 this edge
    logic       w_p2_hits;       // p2 lands a hit on p1 this edge
    logic       w_p1_blocking;
    logic       w_p2_blocking;
    logic [7:0] w_dmg_to_p1;
    logic [7:0] w_dmg_to_p2;
    logic [7:0] w_p1_health_next;
    logic [7:0] w_p2_health_next;
    logic [1:0] w_p1_flag_next;
    logic [1:0] w_p2_flag_next;
    logic       w_round_end;
    logic [1:0] w_winner_next;

    // Overlap of each attacker's hitboxes against the opponent's hurtbox.
    always_comb begin
        w_p1_basic_ov = f_overlap(p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
                                  p2_hurt_x1,  p2_hurt_x2,  p2_hurt_y1,  p2_hurt_y2);
        w_p1_dir_ov   = f_overlap(p1_dir_x1,   p1_dir_x2,   p1_dir_y1,   p1_dir_y2,
                                  p2_hurt_x1,  p2_hurt_x2,  p2_hurt_y1,  p2_hurt_y2);
        w_p2_basic_ov = f_overlap(p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
                                  p1_hurt_x1,  p1_hurt_x2,  p1_hurt_y1,  p1_hurt_y2);
        w_p2_dir_ov   = f_overlap(p2_dir_x1,   p2_dir_x2,   p2_dir_y1,   p2_dir_y2,
                                  p1_hurt_x1,  p1_hurt_x2,  p1_hurt_y1,  p1_hurt_y2);
    end

    // Hit qualification, blocking, damage selection and the resulting
    // next health / flag values. Both directions are resolved independently
    // so a trade updates both sides on the same edge.
    always_comb begin
        w_p1_in_basic  = (p1_state == C_ST_B_END);
        w_p1_in_dir    = (p1_state == C_ST_D_END);
        w_p2_in_basic  = (p2_state == C_ST_B_END);
        w_p2_in_dir    = (p2_state == C_ST_D_END);
        w_p1_attacking = w_p1_in_basic || w_p1_in_dir;
        w_p2_attacking = w_p2_in_basic || w_p2_in_dir;

        w_p1_hits = !r_p1_connected && !r_round_over &&
                    ((w_p1_in_basic && w_p1_basic_ov) || (w_p1_in_dir && w_p1_dir_ov));
        w_p2_hits = !r_p2_connected && !r_round_over &&
                    ((w_p2_in_basic && w_p2_basic_ov) || (w_p2_in_dir && w_p2_dir_ov));

        w_p1_blocking = (p1_state == C_ST_MOVEBACK) || (p1_state == C_ST_BLOCKSTUN);
        w_p2_blocking = (p2_state == C_ST_MOVEBACK) || (p2_state == C_ST_BLOCKSTUN);

        w_dmg_to_p2 = w_p2_blocking ? C_DMG_CHIP :
                      (w_p1_in_basic ? C_DMG_BASIC : C_DMG_DIR);
        w_dmg_to_p1 = w_p1_blocking ? C_DMG_CHIP :
                      (w_p2_in_basic ? C_DMG_BASIC : C_DMG_DIR);

        w_p2_health_next = w_p1_hits ? f_sat_sub(r_p2_health, w_dmg_to_p2) : r_p2_health;
        w_p1_health_next = w_p2_hits ? f_sat_sub(r_p1_health, w_dmg_to_p1) : r_p1_health;

        // The defender's flag reports which attack of the opponent landed.
        w_p2_flag_next = C_FLAG_NONE;
        if (w_p1_hits) begin
            w_p2_flag_next = w_p1_in_basic ? C_FLAG_BASIC : C_FLAG_DIR;
        end
        w_p1_flag_next = C_FLAG_NONE;
        if (w_p2_hits) begin
            w_p1_flag_next = w_p2_in_basic ? C_FLAG_BASIC : C_FLAG_DIR;
        end
    end

    // Round end detection and winner selection; only evaluated while the
    // round is still live, after which everything is frozen.
    always_comb begin
        w_round_end   = !r_round_over &&
                        ((w_p1_health_next == 8'd0) || (w_p2_health_next == 8'd0));
        w_winner_next = C_WIN_NONE;
        if ((w_p1_health_next == 8'd0) && (w_p2_health_next == 8'd0)) begin
            w_winner_next = C_WIN_DRAW;
        end else if (w_p2_health_next == 8'd0) begin
            w_winner_next = C_WIN_P1;
        end else if (w_p1_health_next == 8'd0) begin
            w_winner_next = C_WIN_P2;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Hit pulses and health bars.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_flag   <= C_FLAG_NONE;
            r_p2_flag   <= C_FLAG_NONE;
            r_p1_health <= C_HEALTH_INIT;
            r_p2_health <= C_HEALTH_INIT;
        end else begin
            r_p1_flag   <= w_p1_flag_next;
            r_p2_flag   <= w_p2_flag_next;
            r_p1_health <= w_p1_health_next;
            r_p2_health <= w_p2_health_next;
        end
    end

    // One-hit-per-attack tracking: cleared whenever the attacker leaves the
    // active-frame states, so a fresh attack may connect again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_connected <= 1'b0;
            r_p2_connected <= 1'b0;
        end else begin
            if (!w_p1_attacking) begin
                r_p1_connected <= 1'b0;
            end else if (w_p1_hits) begin
                r_p1_connected <= 1'b1;
            end
            if (!w_p2_attacking) begin
                r_p2_connected <= 1'b0;
            end else if (w_p2_hits) begin
                r_p2_connected <= 1'b1;
            end
        end
    end

    // Sticky round-over latch and the winner captured on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round_over <= 1'b0;
            r_winner     <= C_WIN_NONE;
        end else if (w_round_end) begin
            r_round_over <= 1'b1;
            r_winner     <= w_winner_next;
        end
    end

    assign p1_hitFlag = r_p1_flag;
    assign p2_hitFlag = r_p2_flag;
    assign p1_health  = r_p1_health;
    assign p2_health  = r_p2_health;
    assign round_over = r_round_over;
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_hit_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_resolver
// Brief    : Table-driven, scoreboard-checked bench for hit_resolver, plus
//            hand-written asynchronous-reset and draw sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_resolver;

    logic       clk;
    logic       rst;
    logic       rst2;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
    logic [9:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
    logic [9:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;

    logic [1:0] p1_flag, p2_flag, winner;
    logic [7:0] p1_health, p2_health;
    logic       round_over;

    // Second instance starts at 10 health to reach a double KO in one trade.
    logic [1:0] d2_p1_flag, d2_p2_flag, d2_winner;
    logic [7:0] d2_p1_health, d2_p2_health;
    logic       d2_round_over;

    hit_resolver dut (
        .clk(clk), .rst(rst),
        .p1_state(p1_state),
        .p1_basic_x1(p1_basic_x1), .p1_basic_x2(p1_basic_x2),
        .p1_basic_y1(p1_basic_y1), .p1_basic_y2(p1_basic_y2),
        .p1_dir_x1(p1_dir_x1), .p1_dir_x2(p1_dir_x2),
        .p1_dir_y1(p1_dir_y1), .p1_dir_y2(p1_dir_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
        .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_state(p2_state),
        .p2_basic_x1(p2_basic_x1), .p2_basic_x2(p2_basic_x2),
        .p2_basic_y1(p2_basic_y1), .p2_basic_y2(p2_basic_y2),
        .p2_dir_x1(p2_dir_x1), .p2_dir_x2(p2_dir_x2),
        .p2_dir_y1(p2_dir_y1), .p2_dir_y2(p2_dir_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
        .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_hitFlag(p1_flag), .p2_hitFlag(p2_flag),
        .p1_health(p1_health), .p2_health(p2_health),
        .round_over(round_over), .winner(winner)
    );

    hit_resolver #(.HEALTH_INIT(10)) dut2 (
        .clk(clk), .rst(rst2),
        .p1_state(p1_state),
        .p1_basic_x1(p1_basic_x1), .p1_basic_x2(p1_basic_x2),
        .p1_basic_y1(p1_basic_y1), .p1_basic_y2(p1_basic_y2),
        .p1_dir_x1(p1_dir_x1), .p1_dir_x2(p1_dir_x2),
        .p1_dir_y1(p1_dir_y1), .p1_dir_y2(p1_dir_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
        .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_state(p2_state),
        .p2_basic_x1(p2_basic_x1), .p2_basic_x2(p2_basic_x2),
        .p2_basic_y1(p2_basic_y1), .p2_basic_y2(p2_basic_y2),
        .p2_dir_x1(p2_dir_x1), .p2_dir_x2(p2_dir_x2),
        .p2_dir_y1(p2_dir_y1), .p2_dir_y2(p2_dir_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
        .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_hitFlag(d2_p1_flag), .p2_hitFlag(d2_p2_flag),
        .p1_health(d2_p1_health), .p2_health(d2_p2_health),
        .round_over(d2_round_over), .winner(d2_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s1, s2;
        logic [1:0] g12;   // p2 hurtbox placement: 0 far, 1 overlap, 2 touch x, 3 miss y
        logic       g21;   // p1 hurtbox placement: 0 far, 1 overlap
        logic [1:0] f1, f2;
        logic [7:0] h1, h2;
        logic       ro;
        logic [1:0] win;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [39];
    vec_t sb_q [$];

    function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2,
                                input logic [1:0] g12, input logic g21,
                                input logic [1:0] f1, input logic [1:0] f2,
                                input logic [7:0] h1, input logic [7:0] h2,
                                input logic ro, input logic [1:0] win);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.g12 = g12; v.g21 = g21;
        v.f1 = f1; v.f2 = f2; v.h1 = h1; v.h2 = h2; v.ro = ro; v.win = win;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, row, act, exp);
        end
    endtask

    task automatic set_geo(input logic [1:0] g12, input logic g21);
        case (g12)
            2'd0:    begin p2_hurt_x1 = 10'd501; p2_hurt_x2 = 10'd448; p2_hurt_y1 = 10'd100; p2_hurt_y2 = 10'd400; end
            2'd1:    begin p2_hurt_x1 = 10'd340; p2_hurt_x2 = 10'd300; p2_hurt_y1 = 10'd150; p2_hurt_y2 = 10'd300; end
            2'd2:    begin p2_hurt_x1 = 10'd380; p2_hurt_x2 = 10'd330; p2_hurt_y1 = 10'd100; p2_hurt_y2 = 10'd400; end
            default: begin p2_hurt_x1 = 10'd340; p2_hurt_x2 = 10'd300; p2_hurt_y1 = 10'd228; p2_hurt_y2 = 10'd400; end
        endcase
        if (g21) begin
            p1_hurt_x1 = 10'd120; p1_hurt_x2 = 10'd190; p1_hurt_y1 = 10'd100; p1_hurt_y2 = 10'd400;
        end else begin
            p1_hurt_x1 = 10'd20;  p1_hurt_x2 = 10'd90;  p1_hurt_y1 = 10'd100; p1_hurt_y2 = 10'd400;
        end
    endtask

    task automatic chk_all(input int row, input vec_t e);
        chk("p1_hitFlag", row, {6'd0, p1_flag}, {6'd0, e.f1});
        chk("p2_hitFlag", row, {6'd0, p2_flag}, {6'd0, e.f2});
        chk("p1_health",  row, p1_health, e.h1);
        chk("p2_health",  row, p2_health, e.h2);
        chk("round_over", row, {7'd0, round_over}, {7'd0, e.ro});
        chk("winner",     row, {6'd0, winner}, {6'd0, e.win});
    endtask

    // Watchdog: the run is a few hundred cycles; anything longer is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        rst = 1'b1; rst2 = 1'b1;
        p1_state = 4'd0; p2_state = 4'd0;
        p1_basic_x1 = 10'd245; p1_basic_x2 = 10'd330; p1_basic_y1 = 10'd194; p1_basic_y2 = 10'd227;
        p1_dir_x1   = 10'd250; p1_dir_x2   = 10'd340; p1_dir_y1   = 10'd150; p1_dir_y2   = 10'd200;
        p2_basic_x1 = 10'd250; p2_basic_x2 = 10'd180; p2_basic_y1 = 10'd194; p2_basic_y2 = 10'd227;
        p2_dir_x1   = 10'd240; p2_dir_x2   = 10'd170; p2_dir_y1   = 10'd150; p2_dir_y2   = 10'd200;
        set_geo(2'd0, 1'b0);

        //            s1 s2 g12 g21 f1 f2  h1   h2  ro win
        tbl[0]  = mk(0, 0, 1, 0, 0, 0, 100, 100, 0, 0);  // idle with overlap
        tbl[1]  = mk(3, 0, 1, 0, 0, 0, 100, 100, 0, 0);  // non-active state
        tbl[2]  = mk(4, 0, 1, 0, 0, 1, 100,  90, 0, 0);  // basic hit
        tbl[3]  = mk(4, 0, 1, 0, 0, 0, 100,  90, 0, 0);  // held overlap
        tbl[4]  = mk(4, 0, 1, 0, 0, 0, 100,  90, 0, 0);
        tbl[5]  = mk(5, 0, 1, 0, 0, 0, 100,  90, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 100,  90, 0, 0);
        tbl[7]  = mk(4, 0, 1, 0, 0, 1, 100,  80, 0, 0);  // second attack
        tbl[8]  = mk(5, 0, 1, 0, 0, 0, 100,  80, 0, 0);
        tbl[9]  = mk(7, 2, 1, 0, 0, 2, 100,  78, 0, 0);  // blocked directional
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 100,  78, 0, 0);
        tbl[11] = mk(7, 0, 1, 0, 0, 2, 100,  63, 0, 0);  // clean directional
        tbl[12] = mk(0, 10, 1, 0, 0, 0, 100, 63, 0, 0);
        tbl[13] = mk(4, 10, 1, 0, 0, 1, 100, 61, 0, 0);  // block via blockstun
        tbl[14] = mk(0, 9, 1, 0, 0, 0, 100,  61, 0, 0);
        tbl[15] = mk(4, 9, 1, 0, 0, 1, 100,  51, 0, 0);  // combo into hitstun
        tbl[16] = mk(0, 0, 1, 0, 0, 0, 100,  51, 0, 0);
        tbl[17] = mk(4, 4, 1, 1, 1, 1,  90,  41, 0, 0);  // trade
        tbl[18] = mk(0, 0, 1, 0, 0, 0,  90,  41, 0, 0);
        tbl[19] = mk(4, 0, 3, 0, 0, 0,  90,  41, 0, 0);  // x overlaps, y misses
        tbl[20] = mk(0, 0, 1, 0, 0, 0,  90,  41, 0, 0);
        tbl[21] = mk(4, 0, 2, 0, 0, 1,  90,  31, 0, 0);  // edges just touch
        tbl[22] = mk(0, 0, 1, 0, 0, 0,  90,  31, 0, 0);
        tbl[23] = mk(0, 7, 1, 1, 2, 0,  75,  31, 0, 0);  // p2 directional on p1
        tbl[24] = mk(0, 0, 1, 0, 0, 0,  75,  31, 0, 0);
        tbl[25] = mk(4, 0, 1, 0, 0, 1,  75,  21, 0, 0);
        tbl[26] = mk(0, 0, 1, 0, 0, 0,  75,  21, 0, 0);
        tbl[27] = mk(4, 0, 1, 0, 0, 1,  75,  11, 0, 0);
        tbl[28] = mk(0, 0, 1, 0, 0, 0,  75,  11, 0, 0);
        tbl[29] = mk(4, 2, 1, 0, 0, 1,  75,   9, 0, 0);  // chip
        tbl[30] = mk(0, 0, 1, 0, 0, 0,  75,   9, 0, 0);
        tbl[31] = mk(4, 2, 1, 0, 0, 1,  75,   7, 0, 0);
        tbl[32] = mk(0, 10, 1, 0, 0, 0,  75,  7, 0, 0);
        tbl[33] = mk(4, 10, 1, 0, 0, 1,  75,  5, 0, 0);
        tbl[34] = mk(0, 0, 1, 0, 0, 0,  75,   5, 0, 0);
        tbl[35] = mk(4, 0, 1, 0, 0, 1,  75,   0, 1, 1);  // KO, saturated at 0
        tbl[36] = mk(0, 0, 1, 0, 0, 0,  75,   0, 1, 1);
        tbl[37] = mk(4, 7, 1, 1, 0, 0,  75,   0, 1, 1);  // frozen after round end
        tbl[38] = mk(4, 7, 1, 1, 0, 0,  75,   0, 1, 1);

        // Reset state while reset is held.
        repeat (2) @(negedge clk);
        e = mk(0, 0, 0, 0, 0, 0, 100, 100, 0, 0);
        chk_all(-1, e);
        rst = 1'b0;

        // Table: expectations queued at drive time, compared one edge later.
        for (int i = 0; i < 39; i++) begin
            p1_state = tbl[i].s1;
            p2_state = tbl[i].s2;
            set_geo(tbl[i].g12, tbl[i].g21);
            sb_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk_all(i, e);
            @(negedge clk);
        end

        // Asynchronous reset clears a finished round with no clock edge.
        p1_state = 4'd0; p2_state = 4'd0;
        #2 rst = 1'b1;
        #1;
        chk("async rst round_over", 100, {7'd0, round_over}, 8'd0);
        chk("async rst winner",     100, {6'd0, winner}, 8'd0);
        chk("async rst p2_health",  100, p2_health, 8'd100);
        chk("async rst p1_health",  100, p1_health, 8'd100);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the middle of a hit pulse.
        p1_state = 4'd4; p2_state = 4'd0;
        set_geo(2'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("pulse p2_hitFlag", 101, {6'd0, p2_flag}, 8'd1);
        chk("pulse p2_health",  101, p2_health, 8'd90);
        #2 rst = 1'b1;
        #1;
        chk("mid-pulse rst p2_hitFlag", 102, {6'd0, p2_flag}, 8'd0);
        chk("mid-pulse rst p2_health",  102, p2_health, 8'd100);
        @(negedge clk);
        p1_state = 4'd0;
        rst = 1'b0;
        rst2 = 1'b0;

        // Trade from full health on dut, double KO on dut2 (health 10).
        @(negedge clk);
        p1_state = 4'd4; p2_state = 4'd4;
        set_geo(2'd1, 1'b1);
        @(posedge clk);
        #1;
        chk("trade p1_hitFlag", 103, {6'd0, p1_flag}, 8'd1);
        chk("trade p2_hitFlag", 103, {6'd0, p2_flag}, 8'd1);
        chk("trade p1_health",  103, p1_health, 8'd90);
        chk("trade p2_health",  103, p2_health, 8'd90);
        chk("draw p1_health",   104, d2_p1_health, 8'd0);
        chk("draw p2_health",   104, d2_p2_health, 8'd0);
        chk("draw round_over",  104, {7'd0, d2_round_over}, 8'd1);
        chk("draw winner",      104, {6'd0, d2_winner}, 8'd3);
        @(negedge clk);
        p1_state = 4'd0; p2_state = 4'd0;
        @(posedge clk);
        #1;
        chk("trade pulse ends p1", 105, {6'd0, p1_flag}, 8'd0);
        chk("trade pulse ends p2", 105, {6'd0, p2_flag}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hit_resolver.md
# hit_resolver

Arbitration block between the two `player` instances. It consumes each player's state and hitbox/hurtbox coordinates and detects attacker-hitbox vs defender-hurtbox overlap during the active attack frames. It produces the one-cycle `hitFlag` pulses that each player FSM samples, tracks both health bars, and latches the end of the round. It sits in the top-level game logic, clocked by the same game tick as the players.

## Interface
- `HEALTH_INIT`, default 100: health loaded at reset (8-bit).
- `DMG_BASIC`, default 10: damage for an unblocked basic hit.
- `DMG_DIR`, default 15: damage for an unblocked directional hit.
- `DMG_CHIP`, default 2: damage for any blocked hit.

Ports (`pN` is `p1` or `p2`; p1 is SIDE=0, left; p2 is SIDE=1, right):
- `clk` in 1: game tick clock.
- `rst` in 1: asynchronous, active-high reset.
- `pN_state` in 4: player's `current_state`.
- `pN_basic_x1/x2/y1/y2` in 10 each: basic hitbox.
- `pN_dir_x1/x2/y1/y2` in 10 each: directional hitbox.
- `pN_hurt_x1/x2/y1/y2` in 10 each: main hurtbox.
- `pN_hitFlag` out 2: to that player's `hitFlag`. 00 = none, 01 = hit by basic, 10 = hit by directional, 11 never driven.
- `pN_health` out 8: remaining health.
- `round_over` out 1: sticky, set when either health reaches 0.
- `winner` out 2: 00 = none, 01 = p1, 10 = p2, 11 = draw. Valid while `round_over` is 1.

## Operation
- State codes: 2 MOVEBACKWARDS, 4 B_ATTACK_END, 7 D_ATTACK_END, 9 HITSTUN, 10 BLOCKSTUN.
- Active frames:
  - Basic hitbox is live only while the attacker's state is 4.
  - Directional hitbox is live only while the attacker's state is 7.
  - No other state produces a hit.
- Box normalisation: for every box, lo = min(x1,x2) and hi = max(x1,x2); same for y. The right player's hurtbox has x1 > x2, and this rule handles it.
- Overlap test: inclusive, unsigned 10-bit, `a_lo <= b_hi && b_lo <= a_hi` on both axes.
- One hit per attack instance:
  - Per attacker there is a `connected` bit. It is set when that attacker lands a hit.
  - It clears on any cycle the attacker's state is neither 4 nor 7.
  - While set, no further hit from that attacker is registered.
- Hit event, attacker A on defender D, sampled on a clock edge:
  - Conditions: A's state is 4 or 7, the matching hitbox overlaps D's hurtbox, A's `connected` is 0, and `round_over` is 0.
  - Effect: D's `hitFlag` is 01 if A's state is 4, 10 if A's state is 7.
- Blocking: the hit counts as blocked if D's state is 2 or 10 on the same sample edge. A blocked hit still pulses `hitFlag`; the player FSM enters blockstun itself.
- Damage per event: `DMG_CHIP` if blocked; otherwise `DMG_BASIC` or `DMG_DIR`.
- Health arithmetic: 8-bit, saturating at 0. The subtraction never wraps, so health 5 minus damage 10 gives 0.
- Defender already in HITSTUN (9): still hittable. Combos are allowed.
- Simultaneous events (trade): both hits are resolved in the same cycle. Both flags pulse and both healths update.
- Round end:
  - When either health becomes 0, `round_over` sets on that same edge.
  - `winner` takes the surviving player, or 11 if both reach 0 on the same edge.
  - After that, all hit events are suppressed and health is frozen until `rst`.

## Timing
- Reset values (async `rst`): `pN_hitFlag` = 00, `pN_health` = `HEALTH_INIT`, `round_over` = 0, `winner` = 00, both `connected` = 0.
- Latency: an overlap sampled on edge k drives `hitFlag`, updated health, and `connected` = 1 out of edge k (registered, valid in cycle k+1).
- `hitFlag` is a single-cycle pulse and returns to 00 on edge k+1. This holds even if overlap persists, because `connected` blocks it.
- `connected` is cleared on the edge that samples the attacker outside states 4 and 7. A new attack (4 → 5 → … → 4) can therefore hit again.
- Reset asserted mid-pulse or mid-attack: all outputs return to their reset values immediately, asynchronously.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Basic hit:** p1_state = 4, p1 basic box (245,194)-(330,227) overlaps p2 hurtbox x 448..501 shifted to overlap, p2_state = 0 → p2_hitFlag = 01 for exactly one cycle; p2_health 100 → 90; p1_hitFlag stays 00.
- **Held overlap:** hold p1_state = 4 with overlap for 2 cycles → only one pulse and one damage. Then 5 → 0 → 4 → second pulse, p2_health = 80.
- **Block:** p1_state = 7 with directional overlap, p2_state = 2 → p2_hitFlag = 10, p2_health −2. Repeat with p2_state = 0 → −15.
- **Trade:** both players in state 4 with mutual overlap on the same edge → both flags = 01 on the same cycle, both healths = 90.
- **Round end:** p2_health = 5, unblocked basic hit → p2_health = 0 (saturated), round_over = 1, winner = 01. A further overlapping attack produces no flag and no health change. Trade at health 10 each → winner = 11.
- **Non-active state / reset:** p1_state = 3 with overlap → no flag. Assert rst during a pulse → flag 00 and health 100 immediately.
